// File: rtl/show_sequencer_pkg.sv
// Shared opcode, colour, sound and state definitions for the Halloween show sequencer.
package show_sequencer_pkg;

   typedef enum logic [1:0] {
      ClsSys   = 2'b00,
      ClsColor = 2'b01,
      ClsSound = 2'b10,
      ClsMove  = 2'b11
   } op_class_e;

   localparam logic [3:0] OpOn     = 4'b0000;
   localparam logic [3:0] OpReset  = 4'b0001;
   localparam logic [3:0] OpGreen  = 4'b0100;
   localparam logic [3:0] OpPurple = 4'b0101;
   localparam logic [3:0] OpOrange = 4'b0110;
   localparam logic [3:0] OpScream = 4'b1000;
   localparam logic [3:0] OpCackle = 4'b1001;
   localparam logic [3:0] OpBoo    = 4'b1010;
   localparam logic [3:0] OpWave   = 4'b1100;
   localparam logic [3:0] OpJaw    = 4'b1101;
   localparam logic [3:0] OpFog    = 4'b1110;

   localparam logic [1:0] ColorOff    = 2'b00;
   localparam logic [1:0] ColorGreen  = 2'b01;
   localparam logic [1:0] ColorPurple = 2'b10;
   localparam logic [1:0] ColorOrange = 2'b11;

   localparam logic [1:0] SndScream = 2'b00;
   localparam logic [1:0] SndCackle = 2'b01;
   localparam logic [1:0] SndBoo    = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDispatch,
      StSound,
      StMove,
      StAdvance
   } state_e;

   // Arg 11 is undefined in every class; system class only defines ON and RESET.
   function automatic logic op_illegal(logic [3:0] op);
      return (op[1:0] == 2'b11) || ((op[3:2] == ClsSys) && op[1]);
   endfunction

endpackage

// File: rtl/show_sequencer_if.sv
// Output bundle from the sequencer to the light, sound and actuator drivers.
interface show_sequencer_if;
   logic [1:0] color;
   logic       sound_req;
   logic [1:0] sound_id;
   logic       sound_ack;
   logic [2:0] move_en;

   modport master (output color, sound_req, sound_id, move_en, input sound_ack);
   modport slave  (input color, sound_req, sound_id, move_en, output sound_ack);
endinterface

// File: rtl/show_sequencer_timer.sv
// Loadable down-counter with a zero flag; shared by the sound-timeout and movement phases.
module show_timer #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/show_sequencer.sv
// Plays a stored program of 4-bit show opcodes: colour state, sound handshake, timed movements.
module show_sequencer
   import show_sequencer_pkg::*;
#(
   parameter int unsigned SLOTS       = 4,
   parameter int unsigned MOVE_CYCLES = 8,
   parameter int unsigned ACK_TIMEOUT = 16,
   localparam int unsigned PC_W       = $clog2(SLOTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 prog_load,
   input  logic [SLOTS*4-1:0]   prog_data,
   show_sequencer_if.master     drv,
   output logic [PC_W-1:0]      pc,
   output logic                 busy,
   output logic                 loop_done,
   output logic                 illegal_op,
   output logic                 snd_timeout
);

   localparam int unsigned TmrMax = (MOVE_CYCLES > ACK_TIMEOUT) ? MOVE_CYCLES : ACK_TIMEOUT;
   localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [3:0]       op_q, op_d;
   logic [3:0]       store_q [SLOTS];
   logic [3:0]       store_d [SLOTS];
   logic [1:0]       color_q, color_d;
   logic             sound_req_q, sound_req_d;
   logic [1:0]       sound_id_q, sound_id_d;
   logic [2:0]       move_en_q, move_en_d;
   logic             loop_done_q, loop_done_d;
   logic             illegal_q, illegal_d;
   logic             timeout_q, timeout_d;
   logic             tmr_load, tmr_dec, tmr_zero;
   logic [TmrW-1:0]  tmr_val;

   show_timer #(
      .Width (TmrW)
   ) u_timer (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      op_d        = op_q;
      store_d     = store_q;
      color_d     = color_q;
      sound_req_d = sound_req_q;
      sound_id_d  = sound_id_q;
      move_en_d   = move_en_q;
      loop_done_d = 1'b0;
      illegal_d   = illegal_q;
      timeout_d   = timeout_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      tmr_dec     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (prog_load) begin
               for (int i = 0; i < SLOTS; i++) store_d[i] = prog_data[4*i +: 4];
            end
            if (en) begin
               pc_d    = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            op_d    = store_q[pc_q];
            state_d = StDispatch;
         end
         StDispatch: begin
            state_d = StAdvance;
            if (op_illegal(op_q)) begin
               illegal_d = 1'b1;
            end else begin
               unique case (op_class_e'(op_q[3:2]))
                  ClsSys: begin
                     // RESET restarts the program without counting as a completed loop.
                     if (op_q == OpReset) begin
                        pc_d    = '0;
                        state_d = StFetch;
                     end
                  end
                  ClsColor: color_d = op_q[1:0] + 2'd1;
                  ClsSound: begin
                     sound_req_d = 1'b1;
                     sound_id_d  = op_q[1:0];
                     tmr_load    = 1'b1;
                     tmr_val     = TmrW'(ACK_TIMEOUT - 1);
                     state_d     = StSound;
                  end
                  ClsMove: begin
                     move_en_d = 3'b001 << op_q[1:0];
                     tmr_load  = 1'b1;
                     tmr_val   = TmrW'(MOVE_CYCLES - 1);
                     state_d   = StMove;
                  end
                  default: ;
               endcase
            end
         end
         StSound: begin
            if (drv.sound_ack) begin
               sound_req_d = 1'b0;
               state_d     = StAdvance;
            end else if (tmr_zero) begin
               sound_req_d = 1'b0;
               timeout_d   = 1'b1;
               state_d     = StAdvance;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         StMove: begin
            if (tmr_zero) begin
               move_en_d = '0;
               state_d   = StAdvance;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         StAdvance: begin
            if (pc_q == PC_W'(SLOTS - 1)) begin
               pc_d        = '0;
               loop_done_d = 1'b1;
            end else begin
               pc_d = pc_q + 1'b1;
            end
            state_d = en ? StFetch : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         op_q        <= '0;
         for (int i = 0; i < SLOTS; i++) store_q[i] <= '0;
         color_q     <= '0;
         sound_req_q <= 1'b0;
         sound_id_q  <= '0;
         move_en_q   <= '0;
         loop_done_q <= 1'b0;
         illegal_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         op_q        <= op_d;
         store_q     <= store_d;
         color_q     <= color_d;
         sound_req_q <= sound_req_d;
         sound_id_q  <= sound_id_d;
         move_en_q   <= move_en_d;
         loop_done_q <= loop_done_d;
         illegal_q   <= illegal_d;
         timeout_q   <= timeout_d;
      end
   end

   assign drv.color     = color_q;
   assign drv.sound_req = sound_req_q;
   assign drv.sound_id  = sound_id_q;
   assign drv.move_en   = move_en_q;
   assign pc            = pc_q;
   assign busy          = (state_q != StIdle);
   assign loop_done     = loop_done_q;
   assign illegal_op    = illegal_q;
   assign snd_timeout   = timeout_q;

endmodule
